// File: rtl/vfifo_sc_fifo_ctrl.sv
// rtl/vfifo_sc_fifo_ctrl.sv - single-clock FIFO controller over an external dual-port RAM
// A 2-entry output buffer hides the one-cycle RAM read latency so the read side streams at full rate.
module vfifo_sc_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH-1:0] ram_adr_a,
    output logic [DATA_WIDTH-1:0] ram_d_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_adr_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  almost_full
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam int CW = ADDR_WIDTH + 2;
    localparam logic [PW-1:0] DEPTH_P = PW'(1 << ADDR_WIDTH);
    localparam logic [PW-1:0] AF_P    = PW'(AF_LEVEL);

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         ram_cnt;
    logic [1:0]            ob_cnt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] ob0;
    logic [DATA_WIDTH-1:0] ob1;
    logic                  full;
    logic                  ram_empty;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            pend;
    logic                  cap_slot1;

    always_comb begin
        ram_cnt   = wptr - rptr;
        full      = (ram_cnt == DEPTH_P);
        ram_empty = (ram_cnt == '0);
        s_ready   = !full && !rst;
        m_valid   = (ob_cnt != 2'd0);
        m_data    = ob0;
        push      = s_valid && s_ready;
        pop       = m_valid && m_ready;
        // Buffer slots that will be committed after this edge; a read may only be
        // issued if its data is guaranteed a free slot when it returns.
        pend      = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
        issue     = !ram_empty && (pend < 3'd2);
        cap_slot1 = (ob_cnt == 2'd2 && pop) || (ob_cnt == 2'd1 && !pop);
        ram_adr_a = wptr[ADDR_WIDTH-1:0];
        ram_adr_b = rptr[ADDR_WIDTH-1:0];
        ram_d_a   = s_data;
        ram_we_a  = push;
        count     = CW'(ram_cnt) + CW'(ob_cnt) + CW'(inflight);
        almost_full = (ram_cnt >= AF_P);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ob_cnt   <= 2'd0;
            inflight <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (issue) begin
                rptr <= rptr + PW'(1);
            end
            inflight <= issue;
            ob_cnt   <= pend[1:0];
        end
    end

    // Data slots carry no reset; ob_cnt alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (pop) begin
                ob0 <= ob1;
            end
            if (inflight) begin
                if (cap_slot1) begin
                    ob1 <= ram_q_b;
                end else begin
                    ob0 <= ram_q_b;
                end
            end
        end
    end
endmodule

// File: tb/tb_vfifo_sc_fifo_ctrl.sv
// tb/tb_vfifo_sc_fifo_ctrl.sv - self-checking bench for vfifo_sc_fifo_ctrl
// Queue-based reference model plus vector table and directed/random phases.
module tb_vfifo_sc_fifo_ctrl;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int AF = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [AW-1:0] ram_adr_a;
    logic [DW-1:0] ram_d_a;
    logic          ram_we_a;
    logic [AW-1:0] ram_adr_b;
    logic [DW-1:0] ram_q_b;
    logic [AW+1:0] count;
    logic          almost_full;

    vfifo_sc_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .ram_adr_a(ram_adr_a), .ram_d_a(ram_d_a), .ram_we_a(ram_we_a),
        .ram_adr_b(ram_adr_b), .ram_q_b(ram_q_b), .count(count), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
        ram_q_b <= mem[ram_adr_b];
    end

    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] ramq[$];
    logic [DW-1:0] inflq[$];
    logic [DW-1:0] obq[$];
    logic [DW-1:0] popped[$];
    logic [DW-1:0] sentq[$];
    bit            last_push;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit exp_sr;
        exp_sr = !rst && ramq.size() < DEPTH;
        check("s_ready", s_ready, exp_sr);
        check("m_valid", m_valid, obq.size() > 0);
        if (obq.size() > 0) check("m_data", m_data, obq[0]);
        check("count", count, ramq.size() + inflq.size() + obq.size());
        check("almost_full", almost_full, ramq.size() >= AF);
        check("ram_we_a", ram_we_a, exp_sr && s_valid);
        if (exp_sr && s_valid) check("ram_d_a", ram_d_a, s_data);
        if (prev_stall) check("stall_stable", m_data, prev_data);
    endtask

    task automatic drive(input logic r, input logic sv, input logic [DW-1:0] sd, input logic mr);
        @(negedge clk);
        rst = r; s_valid = sv; s_data = sd; m_ready = mr;
        #1;
        check_model();
    endtask

    task automatic tick();
        bit push, pop, issue;
        int pend;
        @(posedge clk);
        last_push = 0;
        prev_stall = 0;
        if (rst) begin
            ramq.delete(); inflq.delete(); obq.delete();
        end else begin
            push = s_valid && ramq.size() < DEPTH;
            pop = m_ready && obq.size() > 0;
            prev_stall = obq.size() > 0 && !m_ready;
            if (prev_stall) prev_data = obq[0];
            pend = obq.size() + inflq.size() - (pop ? 1 : 0);
            issue = ramq.size() > 0 && pend < 2;
            if (pop) popped.push_back(obq.pop_front());
            if (inflq.size() > 0) obq.push_back(inflq.pop_front());
            if (issue) inflq.push_back(ramq.pop_front());
            if (push) ramq.push_back(s_data);
            last_push = push;
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
    endtask

    typedef struct {
        logic          r;
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          e_sr;
        logic          e_mv;
        logic [DW-1:0] e_md;
        int            e_cnt;
    } vec_t;
    vec_t tbl[17];

    initial begin
        int sent, cyc;
        // single word latency, then reset with count=5 and a read in flight
        tbl[0]  = '{0, 1, 32'hA5, 1, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 1, 0, 0, 1};
        tbl[2]  = '{0, 0, 0, 1, 1, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, 1, 1, 1, 32'hA5, 1};
        tbl[4]  = '{0, 0, 0, 1, 1, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 0, 1, 0, 0, 0};
        tbl[6]  = '{0, 1, 2, 0, 1, 0, 0, 1};
        tbl[7]  = '{0, 1, 3, 0, 1, 0, 0, 2};
        tbl[8]  = '{0, 1, 4, 0, 1, 1, 1, 3};
        tbl[9]  = '{0, 1, 5, 0, 1, 1, 1, 4};
        tbl[10] = '{0, 1, 6, 1, 1, 1, 1, 5};
        tbl[11] = '{1, 0, 0, 0, 0, 1, 2, 5};
        tbl[12] = '{0, 1, 32'h11, 1, 1, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 1, 1, 0, 0, 1};
        tbl[14] = '{0, 0, 0, 1, 1, 0, 0, 1};
        tbl[15] = '{0, 0, 0, 1, 1, 1, 32'h11, 1};
        tbl[16] = '{0, 0, 0, 1, 1, 0, 0, 0};

        repeat (2) @(posedge clk);
        do_reset();
        drive(1'b1, 1'b1, 32'h55, 1'b1);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_count", count, 0);
        check("rst_m_valid", m_valid, 1'b0);
        tick();

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].r, tbl[i].sv, tbl[i].sd, tbl[i].mr);
            check($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].e_sr);
            check($sformatf("vec%0d_m_valid", i), m_valid, tbl[i].e_mv);
            if (tbl[i].e_mv) check($sformatf("vec%0d_m_data", i), m_data, tbl[i].e_md);
            check($sformatf("vec%0d_count", i), count, tbl[i].e_cnt);
            tick();
        end

        // fill with reader stalled, then drain
        do_reset();
        sent = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b1, sent, 1'b0);
            tick();
            if (last_push) sent++;
        end
        drive(1'b0, 1'b1, sent, 1'b0);
        check("fill_accepted", sent, 10);
        check("fill_count", count, 10);
        check("fill_s_ready", s_ready, 1'b0);
        check("fill_almost_full", almost_full, 1'b1);
        popped.delete();
        for (int k = 0; k < 15; k++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        check("drain_s_ready", s_ready, 1'b1);
        check("drain_count", count, 0);
        check("drain_len", popped.size(), 10);
        for (int k = 0; k < popped.size() && k < 10; k++) check("drain_order", popped[k], k);

        // streaming: one word per cycle after 3-cycle latency
        do_reset();
        for (int k = 0; k < 60; k++) begin
            drive(1'b0, 1'b1, 32'h1000 + k, 1'b1);
            if (k >= 3) begin
                check("stream_m_valid", m_valid, 1'b1);
                check("stream_m_data", m_data, 32'h1000 + k - 3);
                check("stream_count", count, 3);
            end
            tick();
        end

        // pointer wrap with periodic read stalls
        do_reset();
        popped.delete();
        sent = 0;
        for (int k = 0; k < 400 && popped.size() < 40; k++) begin
            drive(1'b0, sent < 40, 32'h200 + sent, (k % 4) != 1);
            tick();
            if (last_push) sent++;
        end
        check("wrap_len", popped.size(), 40);
        for (int k = 0; k < popped.size(); k++) check("wrap_order", popped[k], 32'h200 + k);

        // random valid/ready over 1000 pushes
        do_reset();
        popped.delete();
        sentq.delete();
        cyc = 0;
        while (sentq.size() < 1000 && cyc < 20000) begin
            logic [DW-1:0] d;
            d = $urandom;
            drive(1'b0, ($urandom % 4) != 0, d, ($urandom % 3) != 0);
            tick();
            if (last_push) sentq.push_back(d);
            cyc++;
        end
        check("rand_pushes", sentq.size(), 1000);
        for (int k = 0; k < 100 && popped.size() < sentq.size(); k++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            tick();
        end
        check("rand_len", popped.size(), sentq.size());
        for (int k = 0; k < popped.size() && k < sentq.size(); k++)
            check("rand_order", popped[k], sentq[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vfifo_sc_fifo_ctrl.md
VFIFO_SC_FIFO_CTRL -- requirements
Module: vfifo_sc_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, RAM address width; DEPTH = 2^ADDR_WIDTH.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4, almost_full threshold on RAM occupancy.
REQ-004 SHALL have ports, one per line: name  direction  width  meaning:
  clk  in  1  single clock; all state updates on its rising edge.
  rst  in  1  synchronous, active-high reset.
  s_data  in  DATA_WIDTH  write-side word.
  s_valid  in  1  write request.
  s_ready  out  1  write-side can accept.
  m_data  out  DATA_WIDTH  read-side word.
  m_valid  out  1  m_data holds the oldest word.
  m_ready  in  1  read-side consumes.
  ram_adr_a  out  ADDR_WIDTH  RAM write address (port A).
  ram_d_a  out  DATA_WIDTH  RAM write data.
  ram_we_a  out  1  RAM write enable.
  ram_adr_b  out  ADDR_WIDTH  RAM read address (port B); RAM returns data one clk later.
  ram_q_b  in  DATA_WIDTH  RAM registered read data.
  count  out  ADDR_WIDTH+2  total words held (RAM + in-flight + output buffer).
  almost_full  out  1  RAM occupancy >= AF_LEVEL.
REQ-005 SHALL drive both RAM ports from clk only (RAM clk_a and clk_b tied to clk externally); ram_we_b is tied low externally.

Function
REQ-006 SHALL keep write pointer wptr and read pointer rptr, each ADDR_WIDTH+1 bits, wrapping modulo 2^(ADDR_WIDTH+1); ram_adr_a = wptr[ADDR_WIDTH-1:0], ram_adr_b = rptr[ADDR_WIDTH-1:0].
REQ-007 SHALL compute ram_cnt = wptr - rptr (modulo arithmetic); full when ram_cnt == DEPTH, ram_empty when ram_cnt == 0.
REQ-008 SHALL set s_ready = !full && !rst, a function of registered state only (no same-cycle pop-to-push pass-through).
REQ-009 SHALL, on s_valid && s_ready, assert ram_we_a with ram_d_a = s_data and increment wptr at the edge.
REQ-010 SHALL hold a 2-entry output buffer (ob, occupancy ob_cnt 0..2) and an inflight flag marking a RAM read issued last cycle.
REQ-011 SHALL issue a read (increment rptr, set inflight next cycle) when !ram_empty and (ob_cnt + inflight - pop) < 2, where pop = m_valid && m_ready.
REQ-012 SHALL never issue a read of the address written in the same cycle (guaranteed by REQ-011 requiring !ram_empty before the write).
REQ-013 SHALL capture ram_q_b into ob when inflight is set, at the edge ending that cycle, preserving FIFO order.
REQ-014 SHALL present m_data = ob head, m_valid = (ob_cnt != 0); on pop remove the head; simultaneous pop and capture keeps ob_cnt unchanged.
REQ-015 SHALL hold m_data stable while m_valid && !m_ready.
REQ-016 SHALL give latency 3 cycles: word accepted in cycle N into an empty block shows m_valid in cycle N+3.
REQ-017 SHALL sustain one word per cycle throughput when s_valid and m_ready are held high after fill.
REQ-018 SHALL maintain count = ram_cnt + inflight + ob_cnt; maximum DEPTH+2; simultaneous push and pop leave count unchanged.
REQ-019 SHALL assert almost_full when ram_cnt >= AF_LEVEL, combinationally from registered pointers.
REQ-020 SHALL ignore s_valid when s_ready is low and m_ready when m_valid is low (no state change, no error).

Reset
REQ-021 SHALL, while rst is high at a clk edge, clear wptr, rptr, ob_cnt, inflight; outputs after that edge: s_ready 0 (while rst high), m_valid 0, ram_we_a 0, count 0, almost_full 0 (AF_LEVEL > 0); m_data undefined-but-stable.
REQ-022 SHALL discard any in-flight read and buffered data on reset asserted mid-operation; s_ready returns to 1 the first cycle rst is low.

Verification (ADDR_WIDTH=3, DEPTH=8, AF_LEVEL=6)
REQ-023 Single word: push 0xA5 at cycle 0, m_ready=1 -> m_valid first high cycle 3 with m_data 0xA5, count returns to 0 cycle 4.
REQ-024 Fill: push 0..12 with m_ready=0 -> s_ready low once ram_cnt=8 (count=10); almost_full high from ram_cnt=6; drain returns 0..9 in order, then s_ready high.
REQ-025 Streaming: s_valid, m_ready continuously high, data incrementing -> after latency, one word per cycle, no gaps, no loss, count constant.
REQ-026 Backpressure: m_ready toggled pseudo-randomly over 1000 pushes with random s_valid -> scoreboard in-order match, m_data stable while stalled.
REQ-027 Pointer wrap: push/pop 40 words through DEPTH=8 -> correct order across address wrap; full/empty never falsely flagged.
REQ-028 Reset mid-stream: rst high 1 cycle with count=5 and inflight set -> next cycle m_valid 0, count 0; subsequent push 0x11 emerges 3 cycles later, no stale data.
